digit_scan_ctrl: RTL and testbench

Scan controller for an 8-digit multiplexed seven-segment display. It time-shares the segment bus across eight digits by stepping a 3-bit digit index. The index is one-hot decoded to the anode lines, with a blanking gap between digits. New display words pass through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new data.

---
 rtl/digit_pkg.sv | 34 +++
 rtl/hex_to_seg.sv | 11 +
 rtl/digit_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared types and constants for the multiplexed seven-segment display blocks.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package digit_pkg;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_BLANK;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment lookup.
module hex_to_seg
    import digit_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex_seg(i_hex);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-aligned word commit.
//   state | meaning
//   BLANK | all anodes off, gap before digit idx
//   SHOW  | digit idx lit; last SHOW of idx 7 is the frame commit point
module digit_scan_ctrl
    import digit_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic             w_commit;

    logic [31:0] r_disp, r_pend;
    logic [7:0]  r_disp_dp, r_pend_dp;
    logic        r_pend_full, w_pend_full_nxt;
    logic        r_ready, w_xfer;

    logic [7:0]  r_an, w_an_nxt, w_onehot;
    logic [6:0]  r_seg, w_seg_nxt, w_seg;
    logic        r_dp, w_dp_nxt, r_frame_start;
    logic [3:0]  w_nib;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_commit    = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = BLANK;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_commit    = (r_idx == 3'd7);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = BLANK;
            end
        endcase
    end

    // A commit with pend full cannot coincide with a transfer: ready is low then.
    assign w_xfer          = data_valid && r_ready;
    assign w_pend_full_nxt = (w_commit && r_pend_full) ? 1'b0 :
                             (w_xfer ? 1'b1 : r_pend_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp        <= '0;
            r_disp_dp     <= '0;
            r_pend        <= '0;
            r_pend_dp     <= '0;
            r_pend_full   <= 1'b0;
            r_ready       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_pend    <= data;
                r_pend_dp <= dp_in;
            end
            if (w_commit && r_pend_full) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            r_pend_full   <= w_pend_full_nxt;
            r_ready       <= !w_pend_full_nxt;
            r_frame_start <= w_commit;
        end
    end

    assign w_onehot = 8'b0000_0001 << r_idx;
    assign w_nib    = r_disp[{r_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    always_comb begin
        w_an_nxt  = ANODES_OFF;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (r_state == SHOW) begin
            w_an_nxt  = ~(w_onehot & digit_en);
            w_seg_nxt = w_seg;
            w_dp_nxt  = ~r_disp_dp[r_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= ANODES_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign data_ready  = r_ready;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with a cycle-stamped scoreboard of expected display outputs.
module tb_digit_scan_ctrl;

    localparam int TD   = 4;
    localparam int BC   = 2;
    localparam int SLOT = TD + BC;
    localparam int FR   = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  digit_en = 8'hFF;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    digit_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data        (data),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Edges since reset release; at the negedge after edge n, cyc == n.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam logic [31:0] W0 = 32'h76543210;
    localparam logic [31:0] WA = 32'h01234567;
    localparam logic [31:0] WB = 32'hFEDCBA98;
    localparam logic [31:0] WC = 32'h89ABCDEF;
    localparam logic [31:0] WD = 32'h13572468;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("reach_cycle_%0d", n), cyc, n);
    endtask

    task automatic push_frame(input int f, input logic [31:0] w, input logic [7:0] dpw,
                              input logic [7:0] en, input int ndig);
        exp_t e;
        int   base;
        for (int k = 0; k < ndig; k++) begin
            base  = FR * f + SLOT * k;
            e.an  = en[k] ? ~(8'h01 << k) : 8'hFF;
            e.seg = seg_tab[w[4*k +: 4]];
            e.dp  = ~dpw[k];
            e.cyc = base + 3;        sb.push_back(e);
            e.cyc = base + 2 + TD;   sb.push_back(e);
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.cyc = base + 3 + TD;   sb.push_back(e);
            e.cyc = base + SLOT + 2; sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin : sb_checker
        exp_t e;
        while (!rst && sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                check("sb_slot_missed", cyc, e.cyc);
            end else begin
                check($sformatf("an@%0d", cyc),  an,  e.an);
                check($sformatf("seg@%0d", cyc), seg, e.seg);
                check($sformatf("dp@%0d", cyc),  dp,  e.dp);
            end
        end
        check($sformatf("an_single_low@%0d", cyc), ($countones(~an) <= 1), 1);
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_ready", data_ready, 1'b1);
        check("rst_fs", frame_start, 1'b0);

        rst = 1'b0;
        data = W0; dp_in = 8'h01; data_valid = 1'b1;
        push_frame(0, 32'h0, 8'h00, 8'hFF, 8);
        wait_neg(1);
        data_valid = 1'b0;
        check("ready_after_accept", data_ready, 1'b0);
        wait_neg(2);
        check("first_blank_an", an, 8'hFF);
        wait_neg(47);
        check("fs_before_commit", frame_start, 1'b0);
        push_frame(1, W0, 8'h01, 8'hFF, 8);
        wait_neg(48);
        check("fs_commit1", frame_start, 1'b1);
        check("ready_commit1", data_ready, 1'b1);
        wait_neg(49);
        check("fs_one_cycle", frame_start, 1'b0);

        // back-pressure: A then B on consecutive cycles
        wait_neg(50);
        data = WA; dp_in = 8'h80; data_valid = 1'b1;
        wait_neg(51);
        check("ready_after_A", data_ready, 1'b0);
        data = WB; dp_in = 8'h0F;
        wait_neg(95);
        check("B_stalled", data_ready, 1'b0);
        push_frame(2, WA, 8'h80, 8'hFF, 8);
        wait_neg(96);
        check("fs_commit2", frame_start, 1'b1);
        check("ready_after_commit2", data_ready, 1'b1);
        wait_neg(97);
        data_valid = 1'b0;
        check("ready_after_B", data_ready, 1'b0);
        wait_neg(144);
        check("fs_commit3", frame_start, 1'b1);
        check("ready_commit3", data_ready, 1'b1);
        push_frame(3, WB, 8'h0F, 8'hFF, 8);

        // collision: word offered exactly on the commit edge with pend empty
        wait_neg(191);
        data = WC; dp_in = 8'h00; data_valid = 1'b1;
        push_frame(4, WB, 8'h0F, 8'hFF, 8);
        wait_neg(192);
        data_valid = 1'b0;
        check("fs_commit4", frame_start, 1'b1);
        check("ready_collision", data_ready, 1'b0);
        wait_neg(240);
        check("fs_commit5", frame_start, 1'b1);
        check("ready_commit5", data_ready, 1'b1);
        digit_en = 8'h0F;
        push_frame(5, WC, 8'h00, 8'h0F, 8);
        wait_neg(287);
        check("fs_period_pre", frame_start, 1'b0);
        wait_neg(288);
        check("fs_period_48", frame_start, 1'b1);
        digit_en = 8'hFF;
        push_frame(6, WC, 8'h00, 8'hFF, 5);

        // mid-frame reset with a word pending
        wait_neg(300);
        data = WD; dp_in = 8'hFF; data_valid = 1'b1;
        wait_neg(301);
        data_valid = 1'b0;
        check("ready_D_pending", data_ready, 1'b0);
        wait_neg(321);
        check("idx5_an", an, 8'hDF);
        check("idx5_seg", seg, seg_tab[4'hA]);
        wait_neg(322);
        rst = 1'b1;
        #1;
        check("mid_rst_an", an, 8'hFF);
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_dp", dp, 1'b1);
        check("mid_rst_ready", data_ready, 1'b1);
        check("mid_rst_fs", frame_start, 1'b0);
        check("sb_drained_before_rst", sb.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_frame(0, 32'h0, 8'h00, 8'hFF, 8);
        push_frame(1, 32'h0, 8'h00, 8'hFF, 8);
        wait_neg(1);
        check("post_rst_ready", data_ready, 1'b1);
        wait_neg(48);
        check("post_rst_fs", frame_start, 1'b1);
        check("post_rst_ready_commit", data_ready, 1'b1);
        wait_neg(100);
        check("sb_drained_end", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
